xsim_msg_deframer: RTL and testbench



---
 rtl/xsim_portal_pkg.sv | 30 +++
 rtl/xsim_stat_counter.sv | 21 ++
 rtl/xsim_msg_deframer.sv | 156 +++++++++++++++
 tb/tb_xsim_msg_deframer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xsim_portal_pkg.sv
// Shared definitions for the xsim portal receive path: header field layout,
// beat width and the deframer state encoding.
package xsim_portal_pkg;

  localparam int BEAT_W    = 32;
  localparam int METHOD_HI = 31;
  localparam int METHOD_LO = 16;
  localparam int LEN_HI    = 15;
  localparam int LEN_LO    = 0;

  localparam int METHOD_W  = METHOD_HI - METHOD_LO + 1;
  localparam int HDR_LEN_W = LEN_HI - LEN_LO + 1;

  typedef logic [HDR_LEN_W-1:0] hdr_len_t;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DELIVER,
    DISCARD
  } deframer_state_e;

  // The header length counts the header itself, so a length of 0 or 1 means no payload.
  function automatic hdr_len_t payload_words(input logic [BEAT_W-1:0] hdr);
    hdr_len_t len;
    len = hdr[LEN_HI:LEN_LO];
    return (len == '0) ? '0 : len - hdr_len_t'(1);
  endfunction

endpackage

// File: rtl/xsim_stat_counter.sv
// 32-bit wrapping event counter, used for the optional deframer statistics.
module xsim_stat_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/xsim_msg_deframer.sv
// Receives the DPI sink beat stream, rebuilds portal messages and hands them to the
// request demux. Optional statistics outputs are enabled by XSIM_DEFRAMER_STATS_EN.
module xsim_msg_deframer
  import xsim_portal_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = 16
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               beat_valid,
  input  logic [BEAT_W-1:0]                  beat_data,
  output logic                               beat_ready,
  output logic                               msg_valid,
  input  logic                               msg_ready,
  output logic [METHOD_W-1:0]                msg_method,
  output logic [$clog2(MAX_WORDS+1)-1:0]     msg_len,
  output logic [BEAT_W*MAX_WORDS-1:0]        msg_data,
  output logic                               err_oversize
`ifdef XSIM_DEFRAMER_STATS_EN
  ,
  output logic [31:0]                        msg_count,
  output logic [31:0]                        drop_count
`endif
);

  localparam int MLEN_W = $clog2(MAX_WORDS + 1);
  localparam int IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  deframer_state_e                    state_q, state_d;
  logic [METHOD_W-1:0]                method_q, method_d;
  logic [LEN_W-1:0]                   plen_q, plen_d;
  logic [LEN_W-1:0]                   cnt_q, cnt_d;
  logic [MLEN_W-1:0]                  len_q, len_d;
  logic [MAX_WORDS-1:0][BEAT_W-1:0]   data_q, data_d;
  logic                               ready_q, ready_d;
  logic                               valid_q, valid_d;
  logic                               err_q, err_d;

  logic                               beat_fire;
  logic                               msg_fire;
  logic [LEN_W-1:0]                   hdr_p;

  assign beat_fire = beat_valid && ready_q;
  assign msg_fire  = valid_q && msg_ready;
  assign hdr_p     = LEN_W'(payload_words(beat_data));

  always_comb begin
    state_d  = state_q;
    method_d = method_q;
    plen_d   = plen_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    data_d   = data_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (beat_fire) begin
          method_d = beat_data[METHOD_HI:METHOD_LO];
          plen_d   = hdr_p;
          cnt_d    = '0;
          data_d   = '0;
          if (hdr_p == '0) begin
            state_d = DELIVER;
            len_d   = '0;
          end else if (hdr_p > LEN_W'(MAX_WORDS)) begin
            state_d = DISCARD;
            len_d   = '0;
          end else begin
            state_d = PAYLOAD;
            len_d   = MLEN_W'(hdr_p);
          end
        end
      end
      PAYLOAD: begin
        if (beat_fire) begin
          data_d[cnt_q[IDX_W-1:0]] = beat_data;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == plen_q - LEN_W'(1)) begin
            state_d = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (msg_fire) begin
          state_d = IDLE;
        end
      end
      DISCARD: begin
        // Oversize bodies are counted through with the full LEN_W counter and never stored.
        if (beat_fire) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == plen_q - LEN_W'(1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d != DELIVER);
    valid_d = (state_d == DELIVER);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      method_q <= '0;
      plen_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      method_q <= method_d;
      plen_q   <= plen_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign beat_ready   = ready_q;
  assign msg_valid    = valid_q;
  assign msg_method   = method_q;
  assign msg_len      = len_q;
  assign msg_data     = data_q;
  assign err_oversize = err_q;

`ifdef XSIM_DEFRAMER_STATS_EN
  xsim_stat_counter u_msg_counter (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .inc_i   (msg_fire),
    .count_o (msg_count)
  );

  xsim_stat_counter u_drop_counter (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .inc_i   (err_q),
    .count_o (drop_count)
  );
`endif

endmodule

// File: tb/tb_xsim_msg_deframer.sv
// Self-checking bench for xsim_msg_deframer: directed scenarios plus randomized
// traffic scored against a message-level reference queue.
module tb_xsim_msg_deframer;

  localparam int MAX_WORDS = 16;
  localparam int MLEN_W    = $clog2(MAX_WORDS + 1);
  localparam int DATA_W    = 32 * MAX_WORDS;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              beat_valid = 1'b0;
  logic [31:0]       beat_data = '0;
  logic              beat_ready;
  logic              msg_valid;
  logic              msg_ready = 1'b0;
  logic [15:0]       msg_method;
  logic [MLEN_W-1:0] msg_len;
  logic [DATA_W-1:0] msg_data;
  logic              err_oversize;
`ifdef XSIM_DEFRAMER_STATS_EN
  logic [31:0]       msg_count;
  logic [31:0]       drop_count;
`endif

  xsim_msg_deframer #(.MAX_WORDS(MAX_WORDS), .LEN_W(16)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .beat_valid   (beat_valid),
    .beat_data    (beat_data),
    .beat_ready   (beat_ready),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_method   (msg_method),
    .msg_len      (msg_len),
    .msg_data     (msg_data),
    .err_oversize (err_oversize)
`ifdef XSIM_DEFRAMER_STATS_EN
    ,
    .msg_count    (msg_count),
    .drop_count   (drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0]       method;
    int                len;
    logic [DATA_W-1:0] data;
  } msg_t;

  msg_t expQ[$];
  msg_t monMsg;
  int   checkCount = 0;
  int   passCount = 0;
  int   expDelivered = 0;
  int   expDrops = 0;
  int   seenErr = 0;
  int   cyc = 0;
  bit   randomReady = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (randomReady) msg_ready = 1'($urandom_range(0, 1));
  endtask

  // Deliveries are scored here: every message transfer must match the oldest expected message.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (err_oversize) seenErr++;
      if (msg_valid && msg_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_msg", 1, 0);
        end else begin
          monMsg = expQ.pop_front();
          checkOutput("msg_method", msg_method, monMsg.method);
          checkOutput("msg_len", msg_len, monMsg.len);
          checkOutput("msg_data", msg_data, monMsg.data);
          checkOutput("ready_during_deliver", beat_ready, 0);
        end
      end
    end
  end

  task automatic sendBeat(input logic [31:0] d, input int gap);
    bit accepted;
    beat_valid = 1'b0;
    repeat (gap) tick();
    beat_valid = 1'b1;
    beat_data  = d;
    accepted   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (beat_ready) begin
        checkOutput("valid_while_accepting", msg_valid, 0);
        accepted = 1'b1;
        tick();
        break;
      end
      tick();
    end
    beat_valid = 1'b0;
    if (!accepted) checkOutput("beat_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [15:0] method, input logic [15:0] lenField,
                               input int gapMin, input int gapMax);
    int p;
    int hdrCyc;
    logic [31:0] w;
    logic [DATA_W-1:0] d;
    msg_t m;
    p = (lenField == 0) ? 0 : int'(lenField) - 1;
    d = '0;
    sendBeat({method, lenField}, $urandom_range(gapMin, gapMax));
    hdrCyc = cyc;
    for (int i = 0; i < p; i++) begin
      w = $urandom;
      if (i < MAX_WORDS) d[32*i +: 32] = w;
      sendBeat(w, $urandom_range(gapMin, gapMax));
    end
    if (p <= MAX_WORDS) begin
      m.method = method;
      m.len    = p;
      m.data   = d;
      expQ.push_back(m);
      expDelivered++;
      checkOutput("valid_after_last_beat", msg_valid, 1);
      checkOutput("ready_low_in_deliver", beat_ready, 0);
      if (gapMax == 0) checkOutput("valid_latency", (cyc - hdrCyc) + 1, p + 1);
    end else begin
      expDrops++;
      checkOutput("err_after_last_drop", err_oversize, 1);
      checkOutput("no_valid_on_drop", msg_valid, 0);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      if (expQ.size() == 0 && !msg_valid) break;
      tick();
    end
    checkOutput("drain", expQ.size(), 0);
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    #1;
    checkOutput("rst_beat_ready", beat_ready, 0);
    checkOutput("rst_msg_valid", msg_valid, 0);
    checkOutput("rst_msg_method", msg_method, 0);
    checkOutput("rst_msg_len", msg_len, 0);
    checkOutput("rst_msg_data", msg_data, 0);
    checkOutput("rst_err", err_oversize, 0);
`ifdef XSIM_DEFRAMER_STATS_EN
    checkOutput("rst_msg_count", msg_count, 0);
    checkOutput("rst_drop_count", drop_count, 0);
`endif
    expQ.delete();
    expDelivered = 0;
    expDrops     = 0;
    seenErr      = 0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    doReset();

    // Three-word message, delivered at cycle 4, beat_ready low for a single cycle.
    msg_ready = 1'b1;
    sendBeat(32'h0005_0004, 0);
    begin
      msg_t m;
      m.method = 16'h0005;
      m.len    = 3;
      m.data   = '0;
      m.data[31:0]  = 32'hA;
      m.data[63:32] = 32'hB;
      m.data[95:64] = 32'hC;
      sendBeat(32'hA, 0);
      sendBeat(32'hB, 0);
      sendBeat(32'hC, 0);
      expQ.push_back(m);
      expDelivered++;
      checkOutput("t1_valid", msg_valid, 1);
      checkOutput("t1_ready_low", beat_ready, 0);
      tick();
      checkOutput("t1_ready_back", beat_ready, 1);
      checkOutput("t1_valid_cleared", msg_valid, 0);
    end

    // Header-only message.
    applyStimulus(16'h0007, 16'h0001, 0, 0);
    waitDrain();

    // Oversize message is dropped with a single error pulse, then the next header decodes.
    applyStimulus(16'h0002, 16'h0013, 0, 0);
    tick();
    checkOutput("t3_err_one_cycle", err_oversize, 0);
    checkOutput("t3_err_count", seenErr, expDrops);
`ifdef XSIM_DEFRAMER_STATS_EN
    checkOutput("t3_drop_count", drop_count, expDrops);
`endif
    applyStimulus(16'h0003, 16'h0002, 0, 0);
    waitDrain();

    // Gapped payload, then a five-cycle downstream stall.
    msg_ready = 1'b0;
    applyStimulus(16'h00C4, 16'h0005, 3, 3);
    beat_valid = 1'b1;
    beat_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", msg_valid, 1);
      checkOutput("stall_ready", beat_ready, 0);
      checkOutput("stall_method", msg_method, expQ[0].method);
      checkOutput("stall_len", msg_len, expQ[0].len);
      checkOutput("stall_data", msg_data, expQ[0].data);
    end
    beat_valid = 1'b0;
    msg_ready  = 1'b1;
    waitDrain();

    // Reset in the middle of a payload drops the partial message.
    sendBeat(32'h0009_0005, 0);
    sendBeat(32'h1111_1111, 0);
    sendBeat(32'h2222_2222, 0);
    doReset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_rst_no_valid", msg_valid, 0);
    end
    applyStimulus(16'h000A, 16'h0003, 0, 0);
    waitDrain();

    // Back-to-back maximum-size and single-word messages.
    doReset();
    applyStimulus(16'h0011, 16'h0011, 0, 0);
    applyStimulus(16'h0012, 16'h0002, 0, 0);
    waitDrain();
`ifdef XSIM_DEFRAMER_STATS_EN
    checkOutput("b2b_msg_count", msg_count, 2);
`endif

    // Randomized traffic with random downstream backpressure.
    randomReady = 1'b1;
    for (int n = 0; n < 25; n++) begin
      int p;
      logic [15:0] lenField;
      p = ($urandom_range(0, 4) == 0) ? $urandom_range(17, 20) : $urandom_range(0, 16);
      lenField = (p == 0) ? 16'($urandom_range(0, 1)) : 16'(p + 1);
      applyStimulus(16'($urandom), lenField, 0, 2);
    end
    randomReady = 1'b0;
    msg_ready   = 1'b1;
    waitDrain();
    tick();
    checkOutput("final_err_count", seenErr, expDrops);
`ifdef XSIM_DEFRAMER_STATS_EN
    checkOutput("final_msg_count", msg_count, expDelivered);
    checkOutput("final_drop_count", drop_count, expDrops);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
